// File: rtl/bootram_ctrl.sv
// Boot RAM controller: arbitrates the PicoRV32 bus and a byte loader onto four 2Kx8 lanes.
// Optional macro BOOTRAM_CPU_WRITE_PROTECT_EN turns CPU writes into reads (RAM is read-only to the CPU).
module bootram_ctrl #(
  parameter int AW    = 11,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW+1:0]    ld_addr,
  input  logic [7:0]       ld_data,
  output logic             ram_ce,
  output logic             ram_oce,
  output logic [LANES-1:0] ram_wre,
  output logic [AW-1:0]    ram_ad,
  output logic [31:0]      ram_din,
  input  logic [31:0]      ram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t            state_q;
  logic              owner_ld_q;  // current grant belongs to the loader
  logic              last_ld_q;   // most recently served requester was the loader
  logic              mem_ready_q;
  logic              ld_ready_q;
  logic [31:0]       mem_rdata_q;
  logic              ram_ce_q;
  logic [LANES-1:0]  ram_wre_q;
  logic [AW-1:0]     ram_ad_q;
  logic [31:0]       ram_din_q;

  logic              grant_ld_d;
  logic [LANES-1:0]  grant_wre_d;
  logic [AW-1:0]     grant_ad_d;
  logic [31:0]       grant_din_d;
  logic [LANES-1:0]  cpu_wre;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

`ifdef BOOTRAM_CPU_WRITE_PROTECT_EN
  assign cpu_wre = '0;
`else
  assign cpu_wre = mem_wstrb;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_ld_d  = 1'b0;
    grant_wre_d = cpu_wre;
    grant_ad_d  = mem_addr[AW+1:2];
    grant_din_d = mem_wdata;
    if (ld_valid && mem_valid) begin
      grant_ld_d = !last_ld_q;
    end else if (ld_valid) begin
      grant_ld_d = 1'b1;
    end
    if (grant_ld_d) begin
      grant_wre_d = LANES'(1) << ld_addr[1:0];
      grant_ad_d  = ld_addr[AW+1:2];
      grant_din_d = {4{ld_data}};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      owner_ld_q  <= 1'b0;
      last_ld_q   <= 1'b1;
      mem_ready_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      mem_rdata_q <= '0;
      ram_ce_q    <= 1'b0;
      ram_wre_q   <= '0;
      ram_ad_q    <= '0;
      ram_din_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_valid || ld_valid) begin
            state_q    <= ACCESS;
            owner_ld_q <= grant_ld_d;
            ram_ce_q   <= 1'b1;
            ram_wre_q  <= grant_wre_d;
            ram_ad_q   <= grant_ad_d;
            ram_din_q  <= grant_din_d;
          end
        end
        ACCESS: begin
          ram_ce_q  <= 1'b0;
          ram_wre_q <= '0;
          if (ram_wre_q != '0) begin
            state_q     <= RESP;
            mem_ready_q <= !owner_ld_q;
            ld_ready_q  <= owner_ld_q;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Lane data is valid one cycle after the ACCESS edge.
          mem_rdata_q <= ram_dout;
          state_q     <= RESP;
          mem_ready_q <= !owner_ld_q;
          ld_ready_q  <= owner_ld_q;
        end
        RESP: begin
          mem_ready_q <= 1'b0;
          ld_ready_q  <= 1'b0;
          last_ld_q   <= owner_ld_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ready = mem_ready_q;
  assign ld_ready  = ld_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_ce    = ram_ce_q;
  assign ram_oce   = 1'b1;
  assign ram_wre   = ram_wre_q;
  assign ram_ad    = ram_ad_q;
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_bootram_ctrl.sv
// Directed bench for bootram_ctrl with a behavioural four-lane RAM model.
// Expected values follow BOOTRAM_CPU_WRITE_PROTECT_EN when the bench is built with it.
module tb_bootram_ctrl;

  localparam int AW = 11;
`ifdef BOOTRAM_CPU_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic [31:0]   mem_rdata;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [AW+1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          ram_ce;
  logic          ram_oce;
  logic [3:0]    ram_wre;
  logic [AW-1:0] ram_ad;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] lane_mem [4][2048];

  bootram_ctrl #(.AW(AW), .LANES(4)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // 2Kx8 lanes with one-cycle registered read.
  always @(posedge clk) begin
    if (ram_ce) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_wre[i]) lane_mem[i][ram_ad] <= ram_din[8*i +: 8];
        ram_dout[8*i +: 8] <= lane_mem[i][ram_ad];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input int word, input logic [31:0] val);
    for (int i = 0; i < 4; i++) lane_mem[i][word] = val[8*i +: 8];
  endtask

  // Waits on negedges for the selected ready; records lane controls seen while ram_ce is high.
  task automatic wait_ready(input string tag, input bit for_ld, input int exp_lat,
                            output int lat, output int ce_cnt, output logic [3:0] wre,
                            output logic [AW-1:0] ad, output logic [31:0] din, output bit other);
    bit done;
    done = 1'b0; lat = 0; ce_cnt = 0; wre = '0; ad = '0; din = '0; other = 1'b0;
    while (!done) begin
      @(negedge clk);
      lat++;
      if (ram_ce) begin
        ce_cnt++; wre = ram_wre; ad = ram_ad; din = ram_din;
      end
      if (for_ld ? mem_ready : ld_ready) other = 1'b1;
      if (for_ld ? ld_ready : mem_ready) done = 1'b1;
      else if (lat >= 20) begin
        check({tag, "_timeout_lat"}, 32'(lat), 32'(exp_lat));
        done = 1'b1;
      end
    end
  endtask

  task automatic cpu_start(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb; mem_valid = 1'b1;
  endtask

  task automatic ld_start(input logic [AW+1:0] addr, input logic [7:0] data);
    ld_addr = addr; ld_data = data; ld_valid = 1'b1;
  endtask

  task automatic cpu_finish(input string tag, input int exp_lat, input logic [3:0] exp_wre,
                            input logic [31:0] exp_rd);
    int lat, ce_cnt; logic [3:0] wre; logic [AW-1:0] ad; logic [31:0] din; bit other;
    logic [31:0] exp_din;
    exp_din = mem_wdata;
    wait_ready(tag, 1'b0, exp_lat, lat, ce_cnt, wre, ad, din, other);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ce_cycles"}, 32'(ce_cnt), 32'd1);
    check({tag, "_wre"}, 32'(wre), 32'(exp_wre));
    check({tag, "_ad"}, 32'(ad), 32'(mem_addr[AW+1:2]));
    if (exp_wre != 4'b0000) check({tag, "_din"}, din, exp_din);
    check({tag, "_no_ld_ready"}, 32'(other), 32'd0);
    check({tag, "_rdata"}, mem_rdata, exp_rd);
    mem_valid = 1'b0;
  endtask

  task automatic ld_finish(input string tag, input int exp_lat, input logic [3:0] exp_wre,
                           input logic [AW-1:0] exp_ad, input logic [31:0] exp_din);
    int lat, ce_cnt; logic [3:0] wre; logic [AW-1:0] ad; logic [31:0] din; bit other;
    wait_ready(tag, 1'b1, exp_lat, lat, ce_cnt, wre, ad, din, other);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ce_cycles"}, 32'(ce_cnt), 32'd1);
    check({tag, "_wre"}, 32'(wre), 32'(exp_wre));
    check({tag, "_ad"}, 32'(ad), 32'(exp_ad));
    check({tag, "_din"}, din, exp_din);
    check({tag, "_no_mem_ready"}, 32'(other), 32'd0);
    ld_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
    check({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
    check({tag, "_ram_ce"}, 32'(ram_ce), 32'd0);
    check({tag, "_ram_wre"}, 32'(ram_wre), 32'd0);
    check({tag, "_ram_ad"}, 32'(ram_ad), 32'd0);
    check({tag, "_ram_din"}, ram_din, 32'd0);
    check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    check({tag, "_ram_oce"}, 32'(ram_oce), 32'd1);
  endtask

  initial begin
    for (int w = 0; w < 2048; w++) preload(w, 32'h0);
    preload(0, 32'h13B7_2393);
    preload(5, 32'h5566_7788);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Tie right after reset: CPU first, pending loader next.
    @(negedge clk);
    cpu_start(32'h0000_0000, 32'h0, 4'b0000);
    ld_start(13'h1FFE, 8'hA5);
    cpu_finish("tie1_cpu_rd_w0", 3, 4'b0000, 32'h13B7_2393);
    ld_finish("tie1_ld_wr_1ffe", 3, 4'b0100, 11'h7FF, 32'hA5A5_A5A5);

    // CPU partial write; protected builds follow the read path instead.
    @(negedge clk);
    cpu_start(32'h0000_1FFC, 32'hDEAD_BEEF, 4'b0101);
    cpu_finish("cpu_wr_7ff", PROT ? 3 : 2, PROT ? 4'b0000 : 4'b0101,
               PROT ? 32'h00A5_0000 : 32'h13B7_2393);

    // Tie with CPU served last: loader wins, CPU follows.
    @(negedge clk);
    cpu_start(32'h0000_1FFC, 32'h0, 4'b0000);
    ld_start(13'h0001, 8'h3C);
    ld_finish("tie2_ld_wr_0001", 2, 4'b0010, 11'h000, 32'h3C3C_3C3C);
    cpu_finish("tie2_cpu_rd_7ff", 4, 4'b0000, PROT ? 32'h00A5_0000 : 32'h00AD_00EF);

    @(negedge clk);
    cpu_start(32'h0000_0000, 32'h0, 4'b0000);
    cpu_finish("cpu_rd_w0", 3, 4'b0000, 32'h13B7_3C93);

    // Reset during WAIT of a read: no ready, outputs back to reset values.
    @(negedge clk);
    cpu_start(32'h0000_1FFC, 32'h0, 4'b0000);
    @(negedge clk);
    check("rst_wait_access_ce", 32'(ram_ce), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_wait");
    reset = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    check("rst_wait_no_late_ready", 32'(mem_ready), 32'd0);
    cpu_start(32'h0000_1FFC, 32'h0, 4'b0000);
    cpu_finish("post_rst_rd_7ff", 3, 4'b0000, PROT ? 32'h00A5_0000 : 32'h00AD_00EF);

    // Full-word write to word 5, readback, then a loader byte into the same word.
    @(negedge clk);
    cpu_start(32'h0000_0014, 32'hFFFF_FFFF, 4'b1111);
    cpu_finish("cpu_wr_w5", PROT ? 3 : 2, PROT ? 4'b0000 : 4'b1111,
               PROT ? 32'h5566_7788 : 32'h00AD_00EF);
    @(negedge clk);
    cpu_start(32'h0000_0014, 32'h0, 4'b0000);
    cpu_finish("cpu_rd_w5", 3, 4'b0000, PROT ? 32'h5566_7788 : 32'hFFFF_FFFF);
    @(negedge clk);
    ld_start(13'h0015, 8'h11);
    ld_finish("ld_wr_0015", 2, 4'b0010, 11'h005, 32'h1111_1111);
    @(negedge clk);
    cpu_start(32'h0000_0014, 32'h0, 4'b0000);
    cpu_finish("cpu_rd_w5_after_ld", 3, 4'b0000, PROT ? 32'h5566_1188 : 32'hFFFF_11FF);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bootram_ctrl.md
# bootram_ctrl

Sequencing and arbitration controller for the 8 KB boot RAM. The boot RAM is built from four 2Kx8 single-port byte lanes with one-cycle read latency. The block sits between the PicoRV32 native memory bus and the four lane macros, and shares the RAM with a byte-wide loader port used for in-system reprogramming. It owns all lane control signals (ce, oce, wre, ad, din) and returns assembled 32-bit read data.

## Interface
Parameters:
- `AW`, 11, word address width (one lane address per 32-bit word)
- `LANES`, 4, byte lanes; fixed at 4, any other value is unsupported

Ports:
- `clk`  in  1  single clock for the block and all lanes
- `reset`  in  1  synchronous, active-high reset
- `mem_valid`  in  1  CPU request, held until `mem_ready`
- `mem_ready`  out  1  one-cycle completion pulse to CPU
- `mem_addr`  in  32  byte address; bits [AW+1:2] used, others ignored
- `mem_wdata`  in  32  CPU write data
- `mem_wstrb`  in  4  byte strobes; all-zero means read
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1
- `ld_valid`  in  1  loader byte-write request, held until `ld_ready`
- `ld_ready`  out  1  one-cycle completion pulse to loader
- `ld_addr`  in  AW+2  loader byte address; [1:0] selects lane
- `ld_data`  in  8  loader byte
- `ram_ce`  out  1  common chip enable to all lanes
- `ram_oce`  out  1  output clock enable; constant 1
- `ram_wre`  out  4  per-lane write enable; bit i drives lane i (bits [8i+7:8i])
- `ram_ad`  out  AW  common lane address
- `ram_din`  out  32  lane write data, lane i on [8i+7:8i]
- `ram_dout`  in  32  lane read data, lane i on [8i+7:8i]

## Operation
- The FSM has four states: IDLE, ACCESS, WAIT and RESP.
- IDLE: sample `mem_valid` and `ld_valid`.
  - If exactly one is high, grant it.
  - If both are high, grant the requester not granted last. The `last` register resets to "loader", so the CPU wins the first tie after reset.
  - On grant, register `ram_ce`=1, `ram_ad`, `ram_din` and `ram_wre`, then go to ACCESS.
- CPU grant:
  - `ram_ad` = `mem_addr[AW+1:2]`
  - `ram_din` = `mem_wdata`
  - `ram_wre` = `mem_wstrb`
- Loader grant:
  - `ram_ad` = `ld_addr[AW+1:2]`
  - `ram_din` = {4{`ld_data`}}
  - `ram_wre` = one-hot(`ld_addr[1:0]`)
- ACCESS: the lanes sample the controls at the end of this cycle. Clear `ram_ce` and `ram_wre`.
  - Write (`ram_wre`≠0): go to RESP.
  - Read: go to WAIT.
- WAIT: capture `ram_dout` into `mem_rdata` at the end of the cycle, then go to RESP.
- RESP: pulse the granted requester's ready for this cycle only, update `last`, then go to IDLE.
- Requesters deassert valid in the cycle after ready (PicoRV32 behaviour). A valid still high in IDLE is treated as a new request.
- `mem_rdata` holds its last captured value outside RESP.
- `mem_rdata` is not updated on writes.
- A loader grant never asserts `mem_ready`; a CPU grant never asserts `ld_ready`.
- The requester not granted stays pending. It is granted in the next IDLE, so starvation is bounded to one transaction.
- Request signals are not re-sampled after grant. Changes to addr/data during ACCESS, WAIT or RESP are ignored.

## Timing
- Reset values:
  - `mem_ready`, `ld_ready`, `ram_ce`, `ram_wre` are 0.
  - `ram_ad`, `ram_din`, `mem_rdata` are 0.
  - `ram_oce` is 1.
  - State is IDLE and `last` is loader.
- Valid first seen high in IDLE cycle N:
  - write: ready is high in cycle N+2
  - read: ready is high in cycle N+3
- Back-to-back throughput:
  - writes: one transaction per 3 cycles
  - reads: one transaction per 4 cycles
- `ram_ce` is high for exactly one cycle (ACCESS) per transaction.
- Reset asserted in any state: IDLE and all outputs at reset values from the next cycle, with no ready pulse.
  - A write whose ACCESS cycle completed before reset is committed.
  - Otherwise the write is dropped.
  - A read in flight is discarded.

## Configuration
- Macro: `BOOTRAM_CPU_WRITE_PROTECT_EN`.
- Defined:
  - CPU grants force `ram_wre`=0, so a CPU write follows the read timing path and is acknowledged at N+3.
  - `mem_rdata` is updated with the unchanged contents.
  - Loader writes are unaffected.
- Undefined: CPU writes commit as described in Operation.

## Test plan
- CPU read of word 0 after reset, RAM preloaded with 0x13B7_2393 -> `mem_ready` pulses at N+3 with `mem_rdata`=0x13B72393 and `ram_ce` high for one cycle.
- CPU write 0xDEADBEEF with strobe 4'b0101 to word 0x7FF, then read back -> readback is 0xXXADXXEF with bytes 1 and 3 unchanged; read ready at N+3, write ready at N+2.
- Loader writes 0xA5 to byte address 0x1FFE -> `ram_wre`=4'b0100 and `ram_ad`=0x7FF; a CPU read of word 0x7FF shows 0xA5 in bits [23:16].
- `mem_valid` and `ld_valid` rise in the same cycle, twice in a row after reset -> first grant goes to the CPU, second to the loader, and the `last` register alternates.
- Reset asserted during WAIT of a CPU read -> no `mem_ready` pulse, all outputs at reset values the next cycle, and a following read completes normally.
- With `BOOTRAM_CPU_WRITE_PROTECT_EN` defined, CPU writes 0xFFFFFFFF to word 5 -> `ram_wre` stays 0, ready at N+3, and word 5 is unchanged; a loader write to word 5 still commits.
